// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use radix-2 shift-add over a double-width product register;
// DIV/DIVU use restoring shift-subtract. Signed operations run on operand
// magnitudes, and the signs are corrected in the FIX state.
//
// Handshake: start is sampled only while idle (busy = 0). Once accepted,
// busy stays high until the unit returns to IDLE. done pulses for one cycle,
// and HI/LO/dbz hold the final result in that same cycle. start, hi_we and
// lo_we are ignored while busy. The FSM state is the internal 'state'
// register, typed state_t.
module muldiv_iter #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] A_data,
  input  logic [DW-1:0] B_data,
  input  logic          hi_we,
  input  logic          lo_we,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          dbz,
  output logic [DW-1:0] HI,
  output logic [DW-1:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [DW-1:0]     a_abs;
  logic [DW-1:0]     b_abs;
  logic [DW-1:0]     a_raw;
  logic              sign_a;
  logic              sign_b;
  logic [CNT_W-1:0]  cnt;
  logic [2*DW-1:0]   prod;
  logic [DW:0]       rem;
  logic [DW-1:0]     quo;

  // Combinational helpers: operand magnitudes, one iteration step, final fixup.
  logic [DW-1:0]   a_abs_in;
  logic [DW-1:0]   b_abs_in;
  logic [DW:0]     mul_sum;
  logic [2*DW-1:0] prod_step;
  logic [DW:0]     div_shift;
  logic            div_ge;
  logic [DW:0]     rem_step;
  logic [DW-1:0]   quo_step;
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   fix_hi;
  logic [DW-1:0]   fix_lo;
  logic            fix_dbz;
  logic            op_signed;
  logic            in_signed;

  // Iteration datapath and FIX-state result correction.
  always_comb begin
    in_signed = ~op[0];
    a_abs_in  = (in_signed && A_data[DW-1]) ? (~A_data + 1'b1) : A_data;
    b_abs_in  = (in_signed && B_data[DW-1]) ? (~B_data + 1'b1) : B_data;

    mul_sum   = {1'b0, prod[2*DW-1:DW]} + (prod[0] ? {1'b0, a_abs} : {(DW+1){1'b0}});
    prod_step = {mul_sum, prod[DW-1:1]};

    div_shift = {rem[DW-1:0], quo[DW-1]};
    div_ge    = (div_shift >= {1'b0, b_abs});
    rem_step  = div_ge ? (div_shift - {1'b0, b_abs}) : div_shift;
    quo_step  = {quo[DW-2:0], div_ge};

    op_signed = ~op_q[0];
    prod_fix  = prod;
    fix_hi    = '0;
    fix_lo    = '0;
    fix_dbz   = 1'b0;
    if (!op_q[1]) begin
      if (op_signed && (sign_a ^ sign_b)) prod_fix = ~prod + 1'b1;
      fix_hi = prod_fix[2*DW-1:DW];
      fix_lo = prod_fix[DW-1:0];
    end else if (b_abs == '0) begin
      // Divide by zero: all-ones quotient, raw dividend as remainder.
      fix_hi  = a_raw;
      fix_lo  = '1;
      fix_dbz = 1'b1;
    end else begin
      fix_lo = (op_signed && (sign_a ^ sign_b)) ? (~quo + 1'b1) : quo;
      fix_hi = (op_signed && sign_a) ? (~rem[DW-1:0] + 1'b1) : rem[DW-1:0];
    end
  end

  // Control FSM, iteration registers and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      a_abs  <= '0;
      b_abs  <= '0;
      a_raw  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dbz    <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hi_we) HI <= wdata;
          if (lo_we) LO <= wdata;
          if (start) begin
            op_q   <= op;
            a_abs  <= a_abs_in;
            b_abs  <= b_abs_in;
            a_raw  <= A_data;
            sign_a <= A_data[DW-1];
            sign_b <= B_data[DW-1];
            cnt    <= '0;
            prod   <= {{DW{1'b0}}, b_abs_in};
            rem    <= '0;
            quo    <= a_abs_in;
            dbz    <= 1'b0;
            busy   <= 1'b1;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (!op_q[1]) begin
            prod <= prod_step;
          end else begin
            rem <= rem_step;
            quo <= quo_step;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DW-1)) state <= S_FIX;
        end
        S_FIX: begin
          HI    <= fix_hi;
          LO    <= fix_lo;
          dbz   <= fix_dbz;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
